// File: rtl/serial_rx_shifter_fifo.sv
// serial_rx_shifter_fifo: LSB-first RX frame shifter with SM2 filter, stop check and receive FIFO
module serial_rx_shifter_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   serial_clock_i,
  input  logic                   serial_reset_i,
  input  logic                   serial_data_i,
  input  logic                   serial_start_input_shift_reg_i,
  input  logic                   serial_shift_input_shift_reg_i,
  input  logic                   serial_receive_i,
  input  logic [1:0]             serial_mode_i,
  input  logic                   serial_sm2_i,
  input  logic                   serial_read_i,
  input  logic                   serial_clear_err_i,
  output logic [DATA_WIDTH-1:0]  serial_sbuf_rx_o,
  output logic                   serial_scon2_rb8_o,
  output logic                   serial_end_bit_o,
  output logic                   serial_rx_valid_o,
  output logic                   serial_overrun_o,
  output logic                   serial_framing_error_o,
  output logic [LEVEL_WIDTH-1:0] serial_fifo_level_o
);
  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = $clog2(SW + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, n_bits;
  logic [SW-1:0] sh_q, sh_d;
  logic [1:0] mode_q, mode_d;
  logic sm2_q, sm2_d;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LEVEL_WIDTH-1:0] lvl_q, lvl_d;
  logic [DATA_WIDTH:0] head_q, head_d, entry;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic load, stop, accept, full, push, pop, wr_en, rem0;
  assign n_bits = mode_q == 2'd0 ? CW'(DATA_WIDTH) : mode_q == 2'd1 ? CW'(DATA_WIDTH + 1) : CW'(DATA_WIDTH + 2);
  assign load   = state_q == LOAD;
  assign stop   = mode_q[1] ? sh_q[DATA_WIDTH+1] : sh_q[DATA_WIDTH];
  assign accept = mode_q == 2'd0 || !sm2_q || sh_q[DATA_WIDTH];
  assign entry  = {mode_q == 2'd0 ? 1'b0 : sh_q[DATA_WIDTH], sh_q[DATA_WIDTH-1:0]};
  assign full   = lvl_q == LEVEL_WIDTH'(FIFO_DEPTH);
  assign pop    = serial_read_i && lvl_q != '0;
  assign push   = load && accept;
  assign wr_en  = push && (!full || pop);
  assign rem0   = lvl_q == '0 || (pop && lvl_q == LEVEL_WIDTH'(1));
  // Frame FSM: arm on start, store sample k at bit k, hand off to LOAD after N samples
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    mode_d = mode_q;
    sm2_d = sm2_q;
    if (state_q != LOAD && serial_receive_i && serial_start_input_shift_reg_i) begin
      state_d = SHIFT;
      cnt_d = '0;
      sh_d = '0;
      mode_d = serial_mode_i;
      sm2_d = serial_sm2_i;
    end else if (state_q == SHIFT && !serial_receive_i) begin
      state_d = IDLE;
    end else if (state_q == SHIFT && serial_shift_input_shift_reg_i) begin
      for (int i = 0; i < SW; i++) sh_d[i] = cnt_q == CW'(i) ? serial_data_i : sh_q[i];
      cnt_d = cnt_q + CW'(1);
      state_d = cnt_d == n_bits ? LOAD : SHIFT;
    end else if (load) begin
      state_d = IDLE;
    end
  end
  // FIFO bookkeeping; the head register holds its value while the FIFO is empty
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = entry;
    wr_d = wr_q + PW'(wr_en);
    rd_d = rd_q + PW'(pop);
    lvl_d = lvl_q + LEVEL_WIDTH'(wr_en) - LEVEL_WIDTH'(pop);
    head_d = lvl_d == '0 ? head_q : rem0 ? entry : mem_q[rd_d];
    ovr_d = (push && full && !pop) || (ovr_q && !serial_clear_err_i);
    ferr_d = (load && mode_q != 2'd0 && !stop) || (ferr_q && !serial_clear_err_i);
  end
  // State registers
  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      mode_q <= '0;
      sm2_q <= 1'b0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      head_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      mode_q <= mode_d;
      sm2_q <= sm2_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      head_q <= head_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
  end
  assign serial_sbuf_rx_o       = head_q[DATA_WIDTH-1:0];
  assign serial_scon2_rb8_o     = head_q[DATA_WIDTH];
  assign serial_end_bit_o       = load;
  assign serial_rx_valid_o      = lvl_q != '0;
  assign serial_overrun_o       = ovr_q;
  assign serial_framing_error_o = ferr_q;
  assign serial_fifo_level_o    = lvl_q;
endmodule

// File: tb/tb_serial_rx_shifter_fifo.sv
// tb_serial_rx_shifter_fifo: scoreboard bench with a queue-based reference model
module tb_serial_rx_shifter_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, din, start, shift, rcv, sm2, rd, clr;
  logic [1:0] mode;
  logic [DW-1:0] sbuf;
  logic rb8, endb, valid, ovr, ferr;
  logic [2:0] lvl;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW:0] model_q[$];
  int end_q[$];
  logic ovr_m = 1'b0;
  logic ferr_m = 1'b0;
  logic [DW:0] e;
  serial_rx_shifter_fifo dut (
    .serial_clock_i(clk),
    .serial_reset_i(rst),
    .serial_data_i(din),
    .serial_start_input_shift_reg_i(start),
    .serial_shift_input_shift_reg_i(shift),
    .serial_receive_i(rcv),
    .serial_mode_i(mode),
    .serial_sm2_i(sm2),
    .serial_read_i(rd),
    .serial_clear_err_i(clr),
    .serial_sbuf_rx_o(sbuf),
    .serial_scon2_rb8_o(rb8),
    .serial_end_bit_o(endb),
    .serial_rx_valid_o(valid),
    .serial_overrun_o(ovr),
    .serial_framing_error_o(ferr),
    .serial_fifo_level_o(lvl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Monitor: end_bit must land in the predicted cycle; reads must return the model's head
  always @(negedge clk) if (!rst) begin
    if (endb) begin
      if (end_q.size() == 0) chk("unexpected end_bit", 1, 0);
      else chk("end_bit cycle", cyc, end_q.pop_front());
    end
    if (rd && valid) begin
      if (model_q.size() == 0) chk("unexpected data", 1, 0);
      else begin
        e = model_q.pop_front();
        chk("sbuf", {24'd0, sbuf}, {23'd0, e[DW-1:0]});
        chk("rb8", {31'd0, rb8}, {31'd0, e[DW]});
      end
    end else if (rd && model_q.size() != 0) chk("valid on read", 0, 1);
  end
  task automatic check_state(input string name);
    chk({name, " level"}, {29'd0, lvl}, model_q.size());
    chk({name, " valid"}, {31'd0, valid}, {31'd0, model_q.size() != 0});
    chk({name, " overrun"}, {31'd0, ovr}, {31'd0, ovr_m});
    chk({name, " ferr"}, {31'd0, ferr}, {31'd0, ferr_m});
  endtask
  task automatic send_frame(input logic [1:0] m, input logic s, input logic [DW-1:0] d,
                            input logic b9, input logic st, input logic rdl);
    int n;
    logic acc;
    n = m == 2'd0 ? DW : m == 2'd1 ? DW + 1 : DW + 2;
    mode = m;
    sm2 = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = 2'($urandom);
    sm2 = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      din = k < DW ? d[k] : (k == n - 1 && m != 2'd0) ? st : b9;
      shift = 1'b1;
      tick;
      shift = 1'b0;
      din = 1'($urandom);
      if (k != n - 1) repeat ($urandom_range(0, 2)) tick;
    end
    end_q.push_back(cyc);
    acc = m == 2'd0 || !s || (m == 2'd1 ? st : b9);
    if (m != 2'd0 && !st) ferr_m = 1'b1;
    if (acc) begin
      if (model_q.size() < DEPTH || rdl) model_q.push_back({m == 2'd0 ? 1'b0 : (m == 2'd1 ? st : b9), d});
      else ovr_m = 1'b1;
    end
    rd = rdl;
    tick;
    rd = 1'b0;
  endtask
  task automatic do_read;
    rd = 1'b1;
    tick;
    rd = 1'b0;
  endtask
  task automatic do_clear;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    ovr_m = 1'b0;
    ferr_m = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    {din, start, shift, sm2, rd, clr} = '0;
    rcv = 1'b1;
    mode = 2'd0;
    repeat (3) tick;
    check_state("reset");
    chk("reset sbuf", {24'd0, sbuf}, 0);
    rst = 1'b0;
    tick;
    send_frame(2'd1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    check_state("t1 push");
    chk("t1 sbuf", {24'd0, sbuf}, 32'hA5);
    chk("t1 rb8", {31'd0, rb8}, 1);
    do_read;
    check_state("t1 read");
    chk("t1 hold sbuf", {24'd0, sbuf}, 32'hA5);
    send_frame(2'd2, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    check_state("t2 reject");
    send_frame(2'd2, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("t2 sbuf", {24'd0, sbuf}, 32'hFF);
    chk("t2 rb8", {31'd0, rb8}, 1);
    do_read;
    for (int i = 1; i <= 5; i++) send_frame(2'd1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
    check_state("t3 overrun");
    repeat (4) do_read;
    do_clear;
    check_state("t3 clear");
    send_frame(2'd1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t4 sbuf", {24'd0, sbuf}, 32'h5A);
    chk("t4 rb8", {31'd0, rb8}, 0);
    check_state("t4 ferr");
    do_read;
    send_frame(2'd1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_state("t4 sm2 ferr");
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) begin shift = 1'b1; tick; shift = 1'b0; end
    rcv = 1'b0;
    tick;
    rcv = 1'b1;
    repeat (12) begin shift = 1'b1; tick; shift = 1'b0; end
    check_state("t5 rcv drop");
    send_frame(2'd0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
    mode = 2'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) begin shift = 1'b1; tick; shift = 1'b0; end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_q.delete();
    ovr_m = 1'b0;
    ferr_m = 1'b0;
    check_state("t5 reset");
    chk("t5 reset sbuf", {24'd0, sbuf}, 0);
    chk("t5 reset end_bit", {31'd0, endb}, 0);
    send_frame(2'd0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("t5 sbuf", {24'd0, sbuf}, 32'hC3);
    chk("t5 rb8", {31'd0, rb8}, 0);
    do_read;
    for (int i = 0; i < 4; i++) send_frame(2'd1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
    send_frame(2'd1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
    check_state("t6 push+pop full");
    repeat (4) do_read;
    check_state("t6 drained");
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat ($urandom_range(0, 3)) begin shift = 1'b1; tick; shift = 1'b0; end
      end else if ($urandom_range(0, 3) == 0) begin
        shift = 1'b1;
        tick;
        shift = 1'b0;
      end
      send_frame(2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                 model_q.size() != 0 && $urandom_range(0, 3) == 0);
      if (model_q.size() != 0 && $urandom_range(0, 2) == 0) do_read;
      if ($urandom_range(0, 5) == 0) do_clear;
      check_state("random");
    end
    while (model_q.size() != 0) do_read;
    repeat (3) tick;
    check_state("final");
    chk("pending end_bit", end_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_rx_shifter_fifo.md
Name: serial_rx_shifter_fifo

Overview:
Parametrised receive shift register for the EMC08 serial port. It is the successor to the fixed 8-bit RX input shifter. It assembles LSB-first frames of configurable width in modes 0–3, applies SM2 multiprocessor filtering and checks the stop bit. Accepted frames go into a small receive FIFO (SBUF plus RB8 per entry) with overrun and framing-error flags. It sits between the serial RX bit-timing controller (which supplies the start and shift strobes) and the SFR interface (which reads SBUF).

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2.
LEVEL_WIDTH, 3, width of the FIFO level output; must satisfy 2**LEVEL_WIDTH > FIFO_DEPTH.

Ports:
serial_clock_i  in  1  system clock; all logic on rising edge.
serial_reset_i  in  1  reset; synchronous, active-high.
serial_data_i  in  1  RX serial line, sampled on shift strobe.
serial_start_input_shift_reg_i  in  1  one-cycle pulse: start bit detected, arm new frame.
serial_shift_input_shift_reg_i  in  1  one-cycle pulse: sample one bit.
serial_receive_i  in  1  receive enable (REN).
serial_mode_i  in  2  00 mode0, 01 mode1, 10/11 nine-bit modes.
serial_sm2_i  in  1  multiprocessor filter enable.
serial_read_i  in  1  pop FIFO head.
serial_clear_err_i  in  1  clears the overrun and framing-error flags.
serial_sbuf_rx_o  out  DATA_WIDTH  FIFO head data.
serial_scon2_rb8_o  out  1  FIFO head RB8.
serial_end_bit_o  out  1  one-cycle pulse: frame complete.
serial_rx_valid_o  out  1  FIFO non-empty (RI source).
serial_overrun_o  out  1  sticky overrun flag.
serial_framing_error_o  out  1  sticky framing-error flag.
serial_fifo_level_o  out  LEVEL_WIDTH  number of stored frames.

Behaviour:
- Reset: state IDLE, bit counter 0, shift register 0, FIFO empty. All outputs 0. A reset mid-frame discards the partial frame.
- Bits per frame N:
  - mode0: DATA_WIDTH.
  - mode1: DATA_WIDTH+1 (data + stop).
  - nine-bit modes: DATA_WIDTH+2 (data + 9th + stop).
- Mode and SM2 are latched on the start strobe and held for the whole frame.
- FSM IDLE -> SHIFT -> LOAD -> IDLE:
  - IDLE: start strobe with receive=1 -> SHIFT; clear counter and shift register. Shift strobes in IDLE are ignored.
  - SHIFT: each shift strobe samples serial_data_i and increments the counter. Sample k (0-based) is data bit k for k<DATA_WIDTH, then the 9th bit (nine-bit modes only), then the stop bit. When the counter reaches N -> LOAD.
  - SHIFT, receive=0 -> IDLE; nothing pushed, no end_bit.
  - SHIFT, another start strobe -> restart the frame (counter 0).
  - LOAD (exactly one cycle): serial_end_bit_o=1 for every completed frame; apply accept/push rules; -> IDLE. A start strobe arriving during LOAD is honoured in the following IDLE cycle only if it is still asserted.
- Latency: end_bit is high in the cycle after the edge that samples the last bit. A pushed frame is visible on the outputs (valid, sbuf, rb8, level) one cycle after LOAD.
- RB8 per frame: mode0 -> 0; mode1 -> stop bit; nine-bit modes -> 9th bit.
- Accept rule:
  - mode0: always.
  - mode1: sm2=0 or stop=1.
  - nine-bit modes: sm2=0 or 9th=1.
  - A rejected frame still pulses end_bit but is not pushed.
- Framing error: modes 1–3 with stop=0 set serial_framing_error_o. This happens whether or not the frame is accepted.
- FIFO push/pop rules:
  - Accepted push while full (no simultaneous read): frame dropped, overrun set, contents unchanged.
  - Push and read in the same cycle while full: both occur, level unchanged, no overrun.
  - Read while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO head outputs: sbuf and rb8 always reflect the head entry, and hold their last value when the FIFO is empty.
- Flags: overrun and framing error clear only on serial_clear_err_i or reset. If a set condition and clear occur in the same cycle, set wins.

Test Plan:
1. Mode1, DATA_WIDTH=8: start, then bits of 0xA5 LSB-first, then stop=1 -> end_bit pulse; one cycle later rx_valid=1, sbuf=0xA5, rb8=1, level=1. Read -> rx_valid=0, level=0.
2. Mode2, sm2=1: frame 0x3C with 9th=0 -> end_bit pulse, rx_valid stays 0. Then 0xFF with 9th=1 -> sbuf=0xFF, rb8=1.
3. Mode1: push 0x01..0x04 with no reads, then 0x05 -> overrun=1, level=4. Four reads return 0x01,0x02,0x03,0x04. clear_err -> overrun=0.
4. Mode1, sm2=0, stop=0, data 0x5A -> frame pushed (sbuf=0x5A, rb8=0), framing_error=1. Same frame with sm2=1 -> not pushed, framing_error=1.
5. Drop receive after 3 shifts -> no end_bit, level=0. Reset asserted at bit 5 of a mode0 frame -> all outputs 0; the next full mode0 frame of 0xC3 -> sbuf=0xC3, rb8=0.
6. FIFO full (level 4), read asserted in the same cycle as a push of 0x77 -> level stays 4, overrun stays 0, and 0x77 is read out after the 3 older entries.
